// File: rtl/gap_monitor.sv
// Gap monitor: removes ADC mid-scale/calibration offsets, box-car filters current and voltage,
// and classifies the gap (open / breakdown / short) with a debounced FSM and ignition-delay counter.
module gap_monitor #(
    parameter int ADC_W    = 12,
    parameter int CUR_OFS  = -80,
    parameter int VOL_OFS  = 94,
    parameter int AVG_LOG2 = 2,
    parameter int DEB_CYC  = 4,
    parameter int TD_W     = 20
) (
    input  logic                   clk_in,
    input  logic                   sys_rst,
    input  logic [ADC_W-1:0]       ad1_in,
    input  logic [ADC_W-1:0]       ad2_in,
    input  logic                   arm,
    input  logic signed [12:0]     v_open_th,
    input  logic signed [12:0]     v_bd_th,
    input  logic signed [12:0]     i_bd_th,
    output logic signed [12:0]     cur_out,
    output logic signed [12:0]     vol_out,
    output logic                   is_breakdown,
    output logic                   is_short,
    output logic [TD_W-1:0]        td_count,
    output logic                   td_valid,
    output logic                   td_sat
);

    localparam int          DW  = 13;
    localparam int          SW  = DW + AVG_LOG2;
    localparam int unsigned WIN = 1 << AVG_LOG2;
    localparam int          MID = 1 << (ADC_W - 1);
    localparam int          DBW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DBW-1:0]  DEB_LAST = DBW'(DEB_CYC - 1);
    localparam logic [TD_W-1:0] TD_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_OPEN,
        OPEN,
        BREAKDOWN,
        SHORT
    } state_t;

    logic signed [DW-1:0] c_d, v_d, c_q, v_q;
    logic signed [DW-1:0] cwin_q [WIN];
    logic signed [DW-1:0] vwin_q [WIN];
    logic signed [SW-1:0] csum_d, vsum_d, csum_q, vsum_q;

    always_comb begin
        c_d = DW'(int'({1'b0, ad1_in}) - MID - CUR_OFS);
        v_d = DW'(int'({1'b0, ad2_in}) - MID - VOL_OFS);
    end

    // Running sum: add the newest stage-1 sample, drop the one leaving the window.
    always_comb begin
        csum_d = csum_q + SW'(c_q) - SW'(cwin_q[WIN-1]);
        vsum_d = vsum_q + SW'(v_q) - SW'(vwin_q[WIN-1]);
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            c_q    <= '0;
            v_q    <= '0;
            csum_q <= '0;
            vsum_q <= '0;
            for (int unsigned i = 0; i < WIN; i++) begin
                cwin_q[i] <= '0;
                vwin_q[i] <= '0;
            end
        end else begin
            c_q       <= c_d;
            v_q       <= v_d;
            csum_q    <= csum_d;
            vsum_q    <= vsum_d;
            cwin_q[0] <= c_q;
            vwin_q[0] <= v_q;
            for (int unsigned i = 1; i < WIN; i++) begin
                cwin_q[i] <= cwin_q[i-1];
                vwin_q[i] <= vwin_q[i-1];
            end
        end
    end

    assign cur_out = DW'(csum_q >>> AVG_LOG2);
    assign vol_out = DW'(vsum_q >>> AVG_LOG2);

    logic open_c, bd_c;
    assign open_c = (vol_out >= v_open_th);
    assign bd_c   = (vol_out < v_bd_th) && (cur_out >= i_bd_th);

    state_t          state_q;
    logic [DBW-1:0]  deb_q;
    logic            arm_q;
    logic [TD_W-1:0] td_q, td_d;
    logic [TD_W-1:0] td_count_q;
    logic            td_valid_q, td_sat_q, is_bd_q, is_sh_q;

    assign td_d = (td_q == TD_MAX) ? td_q : td_q + TD_W'(1);

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            deb_q      <= '0;
            arm_q      <= 1'b0;
            td_q       <= '0;
            td_count_q <= '0;
            td_valid_q <= 1'b0;
            td_sat_q   <= 1'b0;
            is_bd_q    <= 1'b0;
            is_sh_q    <= 1'b0;
        end else begin
            arm_q      <= arm;
            td_valid_q <= 1'b0;
            if (!arm) begin
                // Disarm takes precedence over any transition pending this cycle.
                state_q  <= IDLE;
                deb_q    <= '0;
                td_sat_q <= 1'b0;
                is_bd_q  <= 1'b0;
                is_sh_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!arm_q) begin
                            state_q  <= WAIT_OPEN;
                            deb_q    <= '0;
                            td_q     <= '0;
                            td_sat_q <= 1'b0;
                        end
                    end
                    WAIT_OPEN: begin
                        td_q <= td_d;
                        if (td_d == TD_MAX) td_sat_q <= 1'b1;
                        if (open_c || bd_c) begin
                            if (deb_q == DEB_LAST) begin
                                deb_q   <= '0;
                                state_q <= open_c ? OPEN : SHORT;
                                is_sh_q <= !open_c;
                            end else begin
                                deb_q <= deb_q + DBW'(1);
                            end
                        end else begin
                            deb_q <= '0;
                        end
                    end
                    OPEN: begin
                        td_q <= td_d;
                        if (td_d == TD_MAX) td_sat_q <= 1'b1;
                        if (bd_c) begin
                            if (deb_q == DEB_LAST) begin
                                deb_q      <= '0;
                                state_q    <= BREAKDOWN;
                                is_bd_q    <= 1'b1;
                                td_count_q <= td_d;
                                td_valid_q <= 1'b1;
                            end else begin
                                deb_q <= deb_q + DBW'(1);
                            end
                        end else begin
                            deb_q <= '0;
                        end
                    end
                    BREAKDOWN, SHORT: begin
                        deb_q <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                        deb_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign is_breakdown = is_bd_q;
    assign is_short     = is_sh_q;
    assign td_count     = td_count_q;
    assign td_valid     = td_valid_q;
    assign td_sat       = td_sat_q;

endmodule

// File: tb/tb_gap_monitor.sv
// Directed bench for gap_monitor: default instance plus an 8-bit delay-counter instance
// driven by the same stimulus.
module tb_gap_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              sys_rst;
    logic [11:0]       ad1, ad2;
    logic              arm;
    logic signed [12:0] v_open_th, v_bd_th, i_bd_th;
    logic signed [12:0] cur1, vol1, cur2, vol2;
    logic              is_bd1, is_sh1, td_valid1, td_sat1;
    logic              is_bd2, is_sh2, td_valid2, td_sat2;
    logic [19:0]       td_count1;
    logic [7:0]        td_count2;

    int errors = 0;
    int checks = 0;
    int tdv1 = 0;
    int tdv2 = 0;

    gap_monitor dut1 (
        .clk_in(clk), .sys_rst(sys_rst), .ad1_in(ad1), .ad2_in(ad2), .arm(arm),
        .v_open_th(v_open_th), .v_bd_th(v_bd_th), .i_bd_th(i_bd_th),
        .cur_out(cur1), .vol_out(vol1), .is_breakdown(is_bd1), .is_short(is_sh1),
        .td_count(td_count1), .td_valid(td_valid1), .td_sat(td_sat1)
    );

    gap_monitor #(.TD_W(8)) dut2 (
        .clk_in(clk), .sys_rst(sys_rst), .ad1_in(ad1), .ad2_in(ad2), .arm(arm),
        .v_open_th(v_open_th), .v_bd_th(v_bd_th), .i_bd_th(i_bd_th),
        .cur_out(cur2), .vol_out(vol2), .is_breakdown(is_bd2), .is_short(is_sh2),
        .td_count(td_count2), .td_valid(td_valid2), .td_sat(td_sat2)
    );

    // td_valid pulse counters, sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (td_valid1 === 1'b1) tdv1++;
        if (td_valid2 === 1'b1) tdv2++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ad(input logic [11:0] a1, input logic [11:0] a2);
        ad1 = a1;
        ad2 = a2;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; arm = 1'b0; set_ad(12'h800, 12'h800);
        v_open_th = 13'sd200; v_bd_th = 13'sd100; i_bd_th = 13'sd307;
        step(3);
        checks++; if (cur1 !== 13'sd0) begin errors++; $display("FAIL reset_cur: got %0d expected 0", cur1); end
        checks++; if (vol1 !== 13'sd0) begin errors++; $display("FAIL reset_vol: got %0d expected 0", vol1); end
        checks++; if (is_bd1 !== 1'b0 || is_sh1 !== 1'b0) begin errors++; $display("FAIL reset_flags: got bd=%b sh=%b expected 0 0", is_bd1, is_sh1); end
        checks++; if (td_count1 !== 20'd0 || td_valid1 !== 1'b0 || td_sat1 !== 1'b0) begin errors++; $display("FAIL reset_td: got cnt=%0d valid=%b sat=%b expected 0 0 0", td_count1, td_valid1, td_sat1); end
        checks++; if (tdv1 != 0) begin errors++; $display("FAIL reset_tdv: got %0d pulses expected 0", tdv1); end
    endtask

    task automatic test_filter();
        sys_rst = 1'b0;
        set_ad(12'h816, 12'h953);
        step(4);
        checks++; if (cur1 !== 13'sd76) begin errors++; $display("FAIL filt_cur_c4: got %0d expected 76", cur1); end
        checks++; if (vol1 !== 13'sd183) begin errors++; $display("FAIL filt_vol_c4: got %0d expected 183", vol1); end
        step(1);
        checks++; if (cur1 !== 13'sd102) begin errors++; $display("FAIL filt_cur_c5: got %0d expected 102", cur1); end
        checks++; if (vol1 !== 13'sd245) begin errors++; $display("FAIL filt_vol_c5: got %0d expected 245", vol1); end
        step(5);
        checks++; if (cur1 !== 13'sd102 || vol1 !== 13'sd245) begin errors++; $display("FAIL filt_c10: got cur=%0d vol=%0d expected 102 245", cur1, vol1); end
    endtask

    task automatic test_filter_extremes();
        set_ad(12'h000, 12'hFFF);
        step(5);
        checks++; if (cur1 !== -13'sd1968) begin errors++; $display("FAIL filt_cur_min: got %0d expected -1968", cur1); end
        checks++; if (vol1 !== 13'sd1953) begin errors++; $display("FAIL filt_vol_max: got %0d expected 1953", vol1); end
        checks++; if (is_bd1 !== 1'b0 || is_sh1 !== 1'b0) begin errors++; $display("FAIL idle_no_arm: got bd=%b sh=%b expected 0 0", is_bd1, is_sh1); end
    endtask

    task automatic test_breakdown();
        int start;
        int lat;
        logic found;
        set_ad(12'h816, 12'h953);
        step(6);
        start = tdv1;
        arm = 1'b1;
        step(1000);
        checks++; if (is_bd1 !== 1'b0 || is_sh1 !== 1'b0) begin errors++; $display("FAIL open_flags: got bd=%b sh=%b expected 0 0", is_bd1, is_sh1); end
        checks++; if (tdv1 != start) begin errors++; $display("FAIL open_tdv: got %0d pulses expected 0", tdv1 - start); end
        set_ad(12'hA16, 12'h891);
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step(1);
            if (is_bd1 === 1'b1) begin found = 1'b1; lat = k; end
        end
        checks++; if (!found) begin errors++; $display("FAIL bd_timeout: got no breakdown expected one within 20 cycles"); end
        checks++; if (td_valid1 !== 1'b1) begin errors++; $display("FAIL bd_td_valid: got %b expected 1 with breakdown entry (lat=%0d)", td_valid1, lat); end
        checks++; if (td_count1 < 20'd1004 || td_count1 > 20'd1011) begin errors++; $display("FAIL bd_td_count: got %0d expected 1004..1011", td_count1); end
        step(5);
        checks++; if (is_bd1 !== 1'b1 || is_sh1 !== 1'b0) begin errors++; $display("FAIL bd_hold: got bd=%b sh=%b expected 1 0", is_bd1, is_sh1); end
        checks++; if (tdv1 != start + 1 || td_valid1 !== 1'b0) begin errors++; $display("FAIL bd_single_pulse: got %0d pulses valid=%b expected 1 0", tdv1 - start, td_valid1); end
    endtask

    task automatic test_short();
        int start;
        int lat;
        logic found;
        arm = 1'b0;
        step(1);
        checks++; if (is_bd1 !== 1'b0) begin errors++; $display("FAIL disarm_bd: got %b expected 0", is_bd1); end
        step(8);
        start = tdv1;
        arm = 1'b1;
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 15 && !found; k++) begin
            step(1);
            if (is_sh1 === 1'b1) begin found = 1'b1; lat = k; end
        end
        checks++; if (!found || lat > 9) begin errors++; $display("FAIL short_latency: got found=%b after %0d cycles expected within 9", found, lat); end
        step(3);
        checks++; if (is_sh1 !== 1'b1 || is_bd1 !== 1'b0) begin errors++; $display("FAIL short_flags: got sh=%b bd=%b expected 1 0", is_sh1, is_bd1); end
        checks++; if (tdv1 != start) begin errors++; $display("FAIL short_tdv: got %0d pulses expected 0", tdv1 - start); end
    endtask

    task automatic test_arm_drop();
        int start;
        logic found;
        arm = 1'b0;
        step(1);
        checks++; if (is_sh1 !== 1'b0) begin errors++; $display("FAIL disarm_short: got %b expected 0", is_sh1); end
        set_ad(12'h816, 12'h953);
        step(6);
        start = tdv1;
        arm = 1'b1;
        step(300);
        arm = 1'b0;
        step(1);
        checks++; if (is_bd1 !== 1'b0 || is_sh1 !== 1'b0) begin errors++; $display("FAIL drop_open_flags: got bd=%b sh=%b expected 0 0", is_bd1, is_sh1); end
        set_ad(12'hA16, 12'h891);
        step(10);
        checks++; if (is_bd1 !== 1'b0 || tdv1 != start) begin errors++; $display("FAIL drop_idle_bd: got bd=%b pulses=%0d expected 0 0", is_bd1, tdv1 - start); end
        set_ad(12'h816, 12'h953);
        step(6);
        arm = 1'b1;
        step(50);
        set_ad(12'hA16, 12'h891);
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step(1);
            if (is_bd1 === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rearm_timeout: got no breakdown expected one within 20 cycles"); end
        checks++; if (td_count1 < 20'd54 || td_count1 > 20'd61) begin errors++; $display("FAIL rearm_td_count: got %0d expected 54..61", td_count1); end
    endtask

    task automatic test_saturation();
        logic found;
        arm = 1'b0;
        step(1);
        set_ad(12'h816, 12'h953);
        step(6);
        arm = 1'b1;
        step(250);
        checks++; if (td_sat2 !== 1'b0) begin errors++; $display("FAIL sat_early: got %b expected 0", td_sat2); end
        step(10);
        checks++; if (td_sat2 !== 1'b1) begin errors++; $display("FAIL sat_set: got %b expected 1", td_sat2); end
        step(40);
        set_ad(12'hA16, 12'h891);
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step(1);
            if (is_bd2 === 1'b1) found = 1'b1;
        end
        checks++; if (!found || td_valid2 !== 1'b1) begin errors++; $display("FAIL sat_bd: got found=%b valid=%b expected 1 1", found, td_valid2); end
        checks++; if (td_count2 !== 8'd255) begin errors++; $display("FAIL sat_td_count: got %0d expected 255", td_count2); end
        checks++; if (td_sat1 !== 1'b0) begin errors++; $display("FAIL wide_no_sat: got %b expected 0", td_sat1); end
        arm = 1'b0;
        step(1);
        checks++; if (td_sat2 !== 1'b0 || is_bd2 !== 1'b0) begin errors++; $display("FAIL sat_disarm: got sat=%b bd=%b expected 0 0", td_sat2, is_bd2); end
    endtask

    task automatic test_reset_mid();
        int start;
        set_ad(12'h816, 12'h953);
        step(6);
        arm = 1'b1;
        step(20);
        start = tdv1;
        sys_rst = 1'b1;
        step(1);
        checks++; if (cur1 !== 13'sd0 || vol1 !== 13'sd0) begin errors++; $display("FAIL midrst_filter: got cur=%0d vol=%0d expected 0 0", cur1, vol1); end
        checks++; if (td_count1 !== 20'd0 || is_bd1 !== 1'b0 || tdv1 != start) begin errors++; $display("FAIL midrst_td: got cnt=%0d bd=%b pulses=%0d expected 0 0 0", td_count1, is_bd1, tdv1 - start); end
        sys_rst = 1'b0;
        arm = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_filter();
        test_filter_extremes();
        test_breakdown();
        test_short();
        test_arm_drop();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
